fluxo_dados_genius_param: RTL and testbench

//   Parametrised datapath for the memory-sequence game, driven by the game FSM (unidade_controle).

---
 rtl/fluxo_dados_genius_param_pkg.sv | 14 +
 rtl/fluxo_dados_genius_param_contador_sat_m.sv | 30 +++
 rtl/fluxo_dados_genius_param.sv | 132 +++++++++++++
 tb/tb_fluxo_dados_genius_param.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/fluxo_dados_genius_param_pkg.sv
// Shared defaults and width helpers for the memory-sequence game datapath.
package fluxo_dados_genius_param_pkg;

    localparam int DEF_N_KEYS    = 4;
    localparam int DEF_ROUNDS    = 16;
    localparam int DEF_TIMEOUT_M = 5000;
    localparam int DEF_SHOW_M    = 2000;

    // Counter/address width for a range of n values, never narrower than one bit.
    function automatic int addr_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fluxo_dados_genius_param_contador_sat_m.sv
// Saturating 0..M-1 up-counter with sync clear; fim stays high at M-1 until cleared.
module contador_sat_m
    import fluxo_dados_genius_param_pkg::*;
#(
    parameter int M = 8,
    parameter int W = addr_w(M)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         zera_s,
    input  logic         conta,
    output logic [W-1:0] Q,
    output logic         fim
);

    localparam logic [W-1:0] LAST = W'(M - 1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            Q <= '0;
        end else if (zera_s) begin
            Q <= '0;
        end else if (conta && (Q != LAST)) begin
            Q <= Q + W'(1);
        end
    end

    assign fim = (Q == LAST);

endmodule

// File: rtl/fluxo_dados_genius_param.sv
// Datapath for the memory-sequence game: sequence memory, round/address counters,
// play register with one-hot check, key edge detector and the two timeout counters.
module fluxo_dados_genius_param
    import fluxo_dados_genius_param_pkg::*;
#(
    parameter int N_KEYS    = DEF_N_KEYS,
    parameter int ROUNDS    = DEF_ROUNDS,
    parameter int TIMEOUT_M = DEF_TIMEOUT_M,
    parameter int SHOW_M    = DEF_SHOW_M,
    parameter int ADDR_W    = addr_w(ROUNDS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              zeraR,
    input  logic              registraR,
    input  logic              zeraCR,
    input  logic              contaCR,
    input  logic              zeraCE,
    input  logic              contaCE,
    input  logic              zeraT,
    input  logic              contaT,
    input  logic              zeraTI,
    input  logic              contaTI,
    input  logic              grava,
    input  logic [N_KEYS-1:0] chaves,
    output logic              jogada_correta,
    output logic              jogada_valida,
    output logic              enderecoIgualRodada,
    output logic              fimCE,
    output logic              fimCR,
    output logic              jogada_feita,
    output logic              timeout,
    output logic              timeout_jogada_inicial,
    output logic [N_KEYS-1:0] leds,
    output logic [ADDR_W-1:0] db_rodada,
    output logic [ADDR_W-1:0] db_contagem,
    output logic [N_KEYS-1:0] db_jogada,
    output logic [N_KEYS-1:0] db_memoria,
    output logic              db_tem_jogada
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROUNDS - 1);

    logic [ADDR_W-1:0] endereco;
    logic [ADDR_W-1:0] rodada;
    logic [ADDR_W-1:0] rd_addr;
    logic [N_KEYS-1:0] jogada;
    logic [N_KEYS-1:0] mem [ROUNDS];
    logic              tem_jogada;
    logic              tem_jogada_q;
    logic [addr_w(TIMEOUT_M)-1:0] t_q;
    logic [addr_w(SHOW_M)-1:0]    ti_q;
    logic              t_fim;
    logic              ti_fim;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            endereco     <= '0;
            rodada       <= '0;
            jogada       <= '0;
            tem_jogada_q <= 1'b0;
        end else begin
            tem_jogada_q <= tem_jogada;

            if (zeraCE)
                endereco <= '0;
            else if (contaCE)
                endereco <= (endereco == LAST_ADDR) ? '0 : endereco + ADDR_W'(1);

            // Round count saturates: the FSM may pulse contaCR past the last round.
            if (zeraCR)
                rodada <= '0;
            else if (contaCR && (rodada != LAST_ADDR))
                rodada <= rodada + ADDR_W'(1);

            if (zeraR)
                jogada <= '0;
            else if (registraR)
                jogada <= chaves;
        end
    end

    // Sequence memory has no reset so the recorded sequence survives a game restart.
    always_ff @(posedge clock) begin
        if (grava)
            mem[rodada] <= chaves;
    end

    assign rd_addr    = grava ? rodada : endereco;
    assign db_memoria = mem[rd_addr];

    assign tem_jogada    = |chaves;
    assign db_tem_jogada = tem_jogada;
    assign jogada_feita  = tem_jogada & ~tem_jogada_q;

    assign jogada_correta = (db_memoria == jogada);
    // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing.
    assign jogada_valida  = (jogada != '0) && ((jogada & (jogada - N_KEYS'(1))) == '0);

    assign enderecoIgualRodada = (endereco == rodada);
    assign fimCE               = (endereco == LAST_ADDR);
    assign fimCR               = (rodada == LAST_ADDR);

    assign leds = (contaTI && reset) ? db_memoria : '0;

    assign db_rodada   = rodada;
    assign db_contagem = endereco;
    assign db_jogada   = jogada;

    contador_sat_m #(.M(TIMEOUT_M)) u_timer_jogada (
        .clock  (clock),
        .reset  (reset),
        .zera_s (zeraT),
        .conta  (contaT),
        .Q      (t_q),
        .fim    (t_fim)
    );

    contador_sat_m #(.M(SHOW_M)) u_timer_inicial (
        .clock  (clock),
        .reset  (reset),
        .zera_s (zeraTI),
        .conta  (contaTI),
        .Q      (ti_q),
        .fim    (ti_fim)
    );

    // Level flags come from the counters' own terminal compare.
    assign timeout                = t_fim  && (t_q  == t_q);
    assign timeout_jogada_inicial = ti_fim && (ti_q == ti_q);

endmodule

// File: tb/tb_fluxo_dados_genius_param.sv
// Directed bench for fluxo_dados_genius_param with N_KEYS=4, ROUNDS=4, TIMEOUT_M=8, SHOW_M=3.
module tb_fluxo_dados_genius_param;

    logic       clock = 1'b0;
    logic       reset;
    logic       zeraR, registraR, zeraCR, contaCR, zeraCE, contaCE;
    logic       zeraT, contaT, zeraTI, contaTI, grava;
    logic [3:0] chaves;
    logic       jogada_correta, jogada_valida, enderecoIgualRodada, fimCE, fimCR;
    logic       jogada_feita, timeout, timeout_jogada_inicial, db_tem_jogada;
    logic [3:0] leds, db_jogada, db_memoria;
    logic [1:0] db_rodada, db_contagem;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    fluxo_dados_genius_param #(
        .N_KEYS(4), .ROUNDS(4), .TIMEOUT_M(8), .SHOW_M(3)
    ) dut (
        .clock(clock), .reset(reset),
        .zeraR(zeraR), .registraR(registraR),
        .zeraCR(zeraCR), .contaCR(contaCR),
        .zeraCE(zeraCE), .contaCE(contaCE),
        .zeraT(zeraT), .contaT(contaT),
        .zeraTI(zeraTI), .contaTI(contaTI),
        .grava(grava), .chaves(chaves),
        .jogada_correta(jogada_correta), .jogada_valida(jogada_valida),
        .enderecoIgualRodada(enderecoIgualRodada),
        .fimCE(fimCE), .fimCR(fimCR),
        .jogada_feita(jogada_feita), .timeout(timeout),
        .timeout_jogada_inicial(timeout_jogada_inicial),
        .leds(leds), .db_rodada(db_rodada), .db_contagem(db_contagem),
        .db_jogada(db_jogada), .db_memoria(db_memoria),
        .db_tem_jogada(db_tem_jogada)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        {zeraR, registraR, zeraCR, contaCR, zeraCE, contaCE} = '0;
        {zeraT, contaT, zeraTI, contaTI, grava} = '0;
        chaves = 4'b0010;

        // 1. reset, then release with a key held
        #22;
        chk("rst_rodada",   db_rodada, 0);
        chk("rst_contagem", db_contagem, 0);
        chk("rst_jogada",   db_jogada, 0);
        chk("rst_timeout",  timeout, 0);
        step();
        reset = 1'b1;
        #1;
        chk("edge_pulse", jogada_feita, 1);
        chk("tem_jogada", db_tem_jogada, 1);
        step();
        chk("edge_once", jogada_feita, 0);

        // 2. record 0001,0010,0100,1000
        for (int i = 0; i < 4; i++) begin
            chaves = 4'(1 << i);
            grava = 1'b1;
            step();
            grava = 1'b0;
            contaCR = 1'b1;
            step();
            contaCR = 1'b0;
        end
        chk("rodada_sat", db_rodada, 3);
        chk("fimCR", fimCR, 1);
        contaCR = 1'b1;
        step();
        contaCR = 1'b0;
        chk("rodada_hold", db_rodada, 3);

        // 3. replay at endereco=1
        contaCE = 1'b1;
        step();
        contaCE = 1'b0;
        chk("end_1", db_contagem, 1);
        chaves = 4'b0010;
        registraR = 1'b1;
        step();
        registraR = 1'b0;
        chk("jogada_reg", db_jogada, 4'b0010);
        chk("correta_1",  jogada_correta, 1);
        chk("valida_1",   jogada_valida, 1);
        chaves = 4'b0110;
        registraR = 1'b1;
        step();
        registraR = 1'b0;
        chk("correta_multi", jogada_correta, 0);
        chk("valida_multi",  jogada_valida, 0);
        zeraR = 1'b1;
        registraR = 1'b1;
        step();
        {zeraR, registraR} = '0;
        chk("zeraR_prio",  db_jogada, 0);
        chk("valida_zero", jogada_valida, 0);

        // 4. address wrap with rodada=2
        zeraCR = 1'b1;
        zeraCE = 1'b1;
        step();
        {zeraCR, zeraCE} = '0;
        contaCR = 1'b1;
        step();
        step();
        contaCR = 1'b0;
        chk("rodada_2", db_rodada, 2);
        for (int k = 1; k <= 4; k++) begin
            contaCE = 1'b1;
            step();
            contaCE = 1'b0;
            chk($sformatf("end_seq%0d", k), db_contagem, k % 4);
            chk($sformatf("fimCE%0d", k), fimCE, (k % 4) == 3);
            chk($sformatf("igual%0d", k), enderecoIgualRodada, (k % 4) == 2);
        end
        zeraCE = 1'b1;
        contaCE = 1'b1;
        step();
        {zeraCE, contaCE} = '0;
        chk("zeraCE_prio", db_contagem, 0);

        // grava together with contaCR writes at the pre-increment rodada (2)
        chaves = 4'b1001;
        grava = 1'b1;
        contaCR = 1'b1;
        step();
        {grava, contaCR} = '0;
        chk("rodada_3", db_rodada, 3);
        contaCE = 1'b1;
        step();
        step();
        contaCE = 1'b0;
        chk("mem2_new", db_memoria, 4'b1001);
        contaCE = 1'b1;
        step();
        contaCE = 1'b0;
        chk("mem3_kept", db_memoria, 4'b1000);

        // 5. play timeout
        contaT = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk($sformatf("timeout_c%0d", k), timeout, k >= 7);
        end
        zeraT = 1'b1;
        step();
        zeraT = 1'b0;
        contaT = 1'b0;
        chk("zeraT_prio", timeout, 0);

        // 6. display timer and leds (endereco=3 -> 1000)
        contaTI = 1'b1;
        #1;
        chk("leds_on", leds, 4'b1000);
        step();
        chk("ti_c1", timeout_jogada_inicial, 0);
        step();
        chk("ti_c2", timeout_jogada_inicial, 1);
        step();
        chk("ti_hold", timeout_jogada_inicial, 1);
        zeraTI = 1'b1;
        step();
        zeraTI = 1'b0;
        chk("ti_zera", timeout_jogada_inicial, 0);
        step();
        reset = 1'b0;
        #1;
        chk("rst_leds", leds, 0);
        chk("rst_ti",   timeout_jogada_inicial, 0);
        chk("rst_end",  db_contagem, 0);
        step();
        reset = 1'b1;
        step();
        chk("ti_after_rst1", timeout_jogada_inicial, 0);
        step();
        chk("ti_after_rst2", timeout_jogada_inicial, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
